// File: rtl/mha_pkg.sv
// Shared attention-block constants and the head-concat FSM state encoding.
// Imported by the concat stage, its buffer and the attention stage.
package mha_pkg;

  localparam int D_W   = 8;
  localparam int DIM   = 16;
  localparam int D_K   = 128;
  localparam int H_NUM = 4;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_COLLECT = 4'b0010,
    S_STREAM  = 4'b0100,
    S_DONE    = 4'b1000
  } state_e;

endpackage

// File: rtl/mha_concat_buf.sv
// DIM x (H_NUM*D_K) concat storage: head-wide write, combinational row read.
// Contents are deliberately never reset.
module mha_concat_buf
  import mha_pkg::*;
#(
  parameter int D_W   = mha_pkg::D_W,
  parameter int DIM   = mha_pkg::DIM,
  parameter int D_K   = mha_pkg::D_K,
  parameter int H_NUM = mha_pkg::H_NUM
) (
  input  logic                                  clk_i,
  input  logic                                  wr_en_i,
  input  logic [$clog2(H_NUM)-1:0]              wr_head_i,
  input  logic [DIM-1:0][D_K-1:0][D_W-1:0]      wr_data_i,
  input  logic [$clog2(DIM)-1:0]                rd_row_i,
  output logic [H_NUM-1:0][D_K-1:0][D_W-1:0]    rd_data_o
);

  // Head h of a row sits in columns [h*D_K +: D_K] once flattened.
  logic [H_NUM-1:0][D_K-1:0][D_W-1:0] mem_q [DIM];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int r = 0; r < DIM; r++) begin
        mem_q[r][wr_head_i] <= wr_data_i[r];
      end
    end
  end

  assign rd_data_o = mem_q[rd_row_i];

endmodule

// File: rtl/mha_head_concat.sv
// Collects H_NUM head matrices into a concat buffer, then streams it
// out one full row per valid/ready beat toward the W_O stage.
module mha_head_concat
  import mha_pkg::*;
#(
  parameter int D_W   = mha_pkg::D_W,
  parameter int DIM   = mha_pkg::DIM,
  parameter int D_K   = mha_pkg::D_K,
  parameter int H_NUM = mha_pkg::H_NUM
) (
  input  logic                              I_CLK,
  input  logic                              I_SYNC_RST,
  input  logic                              I_START,
  input  logic                              I_HEAD_VLD,
  input  logic [DIM-1:0][D_K-1:0][D_W-1:0]  I_HEAD_DATA,
  output logic                              O_HEAD_ACK,
  output logic [$clog2(H_NUM)-1:0]          O_HEAD_IDX,
  output logic                              O_BUSY,
  output logic                              O_ROW_VLD,
  input  logic                              I_ROW_RDY,
  output logic [H_NUM*D_K-1:0][D_W-1:0]     O_ROW_DATA,
  output logic [$clog2(DIM)-1:0]            O_ROW_IDX,
  output logic                              O_ROW_LAST,
  output logic                              O_DONE
);

  localparam int HW   = $clog2(H_NUM);
  localparam int RW   = $clog2(DIM);
  localparam int CW_H = HW + 1;
  localparam int CW_R = RW + 1;

  state_e state_q, state_d;

  logic [CW_H-1:0] head_cnt_q, head_cnt_d;
  logic [CW_R-1:0] row_cnt_q, row_cnt_d;
  logic            vld_d_q;
  logic            ack_q, ack_d;
  logic [HW-1:0]   idx_q, idx_d;

  logic head_evt;
  logic capture;
  logic xfer;
  logic last_head;
  logic last_row;
  logic streaming;

  logic [H_NUM-1:0][D_K-1:0][D_W-1:0] rd_row;

  // Only a fresh rising edge of the level valid counts as a new head.
  assign head_evt  = I_HEAD_VLD & ~vld_d_q;
  assign capture   = (state_q == S_COLLECT) & head_evt;
  assign streaming = (state_q == S_STREAM);
  assign xfer      = streaming & I_ROW_RDY;
  assign last_head = (head_cnt_q == CW_H'(H_NUM - 1));
  assign last_row  = (row_cnt_q == CW_R'(DIM - 1));

  mha_concat_buf #(
    .D_W   (D_W),
    .DIM   (DIM),
    .D_K   (D_K),
    .H_NUM (H_NUM)
  ) u_buf (
    .clk_i     (I_CLK),
    .wr_en_i   (capture),
    .wr_head_i (head_cnt_q[HW-1:0]),
    .wr_data_i (I_HEAD_DATA),
    .rd_row_i  (row_cnt_q[RW-1:0]),
    .rd_data_o (rd_row)
  );

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (I_START) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (capture && last_head) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (xfer && last_row) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    head_cnt_d = head_cnt_q;
    row_cnt_d  = row_cnt_q;
    ack_d      = capture;
    idx_d      = capture ? head_cnt_q[HW-1:0] : '0;
    if ((state_q == S_IDLE) && I_START) begin
      head_cnt_d = '0;
    end
    if (capture) begin
      head_cnt_d = last_head ? '0 : head_cnt_q + CW_H'(1);
      if (last_head) row_cnt_d = '0;
    end
    if (xfer) begin
      row_cnt_d = row_cnt_q + CW_R'(1);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      head_cnt_q <= '0;
      row_cnt_q  <= '0;
      vld_d_q    <= 1'b0;
      ack_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      head_cnt_q <= head_cnt_d;
      row_cnt_q  <= row_cnt_d;
      vld_d_q    <= I_HEAD_VLD;
      ack_q      <= ack_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    O_HEAD_ACK = ack_q;
    O_HEAD_IDX = idx_q;
    O_BUSY     = (state_q != S_IDLE);
    O_ROW_VLD  = streaming;
    O_ROW_DATA = streaming ? rd_row : '0;
    O_ROW_IDX  = streaming ? row_cnt_q[RW-1:0] : '0;
    O_ROW_LAST = streaming & last_row;
    O_DONE     = (state_q == S_DONE);
  end

endmodule
